// File: rtl/systolic_drain.sv
// Drains a captured systolic_array result tile one element per beat, row-major,
// so the array can begin its next tile while this one streams out.
module systolic_drain #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int idx_width_p    = (array_width_p > 1) ? $clog2(array_width_p) : 1
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,
    input  logic [width_p*array_width_p*array_height_p-1:0] z_i,
    input  logic [array_width_p*array_height_p-1:0]         z_valid_i,
    output logic [array_width_p*array_height_p-1:0]         z_yumi_o,
    output logic [width_p-1:0]                              data_o,
    output logic [idx_width_p-1:0]                          row_o,
    output logic [idx_width_p-1:0]                          col_o,
    output logic                                            last_o,
    output logic                                            valid_o,
    input  logic                                            ready_i
);
    localparam int N  = array_width_p * array_height_p;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [idx_width_p-1:0] COL_LAST = idx_width_p'(array_width_p - 1);
    localparam logic [idx_width_p-1:0] ROW_LAST = idx_width_p'(array_height_p - 1);

    if (array_width_p != array_height_p) begin : g_shape_chk
        $error("systolic_drain: array_width_p must equal array_height_p");
    end

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                      state_q, state_d;
    logic [idx_width_p-1:0]      row_q, row_d;
    logic [idx_width_p-1:0]      col_q, col_d;
    logic [N-1:0][width_p-1:0]   buf_q;
    logic                        capture;
    logic                        last;
    logic [PW-1:0]               sel;

    always_comb begin
        capture = reset_i && (state_q == IDLE) && (&z_valid_i);
        last    = (state_q == STREAM) && (row_q == ROW_LAST) && (col_q == COL_LAST);
        // Grid is column-major on the bus: p = r + c*W.
        sel     = PW'(int'(row_q) + int'(col_q) * array_width_p);
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (&z_valid_i) begin
                    state_d = STREAM;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            STREAM: begin
                if (ready_i) begin
                    if (last) begin
                        state_d = IDLE;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer has no reset: it is only observed after a capture.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (capture) buf_q <= z_i;
        end
    end

    assign z_yumi_o = {N{capture}};
    assign valid_o  = (state_q == STREAM);
    assign last_o   = last;
    assign row_o    = row_q;
    assign col_o    = col_q;
    assign data_o   = valid_o ? buf_q[sel] : '0;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed + random bench for systolic_drain against a queue-based tile model.
module tb_systolic_drain;
    localparam int W  = 2;
    localparam int H  = 2;
    localparam int DW = 32;
    localparam int N  = W * H;

    logic              clk;
    logic              reset_i;
    logic [DW*N-1:0]   z_i;
    logic [N-1:0]      z_valid_i;
    logic [N-1:0]      z_yumi_o;
    logic [DW-1:0]     data_o;
    logic [0:0]        row_o, col_o;
    logic              last_o, valid_o, ready_i;

    systolic_drain #(.width_p(DW), .array_width_p(W), .array_height_p(H)) dut (
        .clk_i(clk), .reset_i(reset_i), .z_i(z_i), .z_valid_i(z_valid_i),
        .z_yumi_o(z_yumi_o), .data_o(data_o), .row_o(row_o), .col_o(col_o),
        .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            r;
        int            c;
        bit            last;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    beats  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Element (r,c) sits at flat index p = r + c*W.
    function automatic logic [DW*N-1:0] grid(input int a00, input int a01, input int a10, input int a11);
        logic [DW*N-1:0] z;
        z = '0;
        z[DW*(0 + 0*W) +: DW] = a00;
        z[DW*(0 + 1*W) +: DW] = a01;
        z[DW*(1 + 0*W) +: DW] = a10;
        z[DW*(1 + 1*W) +: DW] = a11;
        return z;
    endfunction

    // One cycle: check at negedge, advance the model at posedge, return at posedge+1.
    task automatic tick();
        logic [N-1:0] exp_yumi;
        beat_t b;
        @(negedge clk);
        exp_yumi = (reset_i && q.size() == 0 && (&z_valid_i)) ? '1 : '0;
        chk("yumi", 32'(z_yumi_o), 32'(exp_yumi));
        chk("valid", 32'(valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            b = q[0];
            chk("data", data_o, b.d);
            chk("row", 32'(row_o), 32'(b.r));
            chk("col", 32'(col_o), 32'(b.c));
            chk("last", 32'(last_o), 32'(b.last));
            if (valid_o && ready_i) beats++;
        end else begin
            chk("last_idle", 32'(last_o), 32'd0);
            chk("row_idle", 32'(row_o), 32'd0);
            chk("col_idle", 32'(col_o), 32'd0);
        end
        @(posedge clk);
        if (!reset_i) begin
            q.delete();
        end else if (q.size() != 0) begin
            if (ready_i) void'(q.pop_front());
        end else if (&z_valid_i) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    q.push_back('{z_i[DW*(r + c*W) +: DW], r, c, (r == H-1) && (c == W-1)});
        end
        #1;
    endtask

    logic [DW*N-1:0] tile1, tile2;

    initial begin
        tile1     = grid(-2103, -3707, 21950, 30);
        tile2     = grid(81, 1092, 162, 2069);
        reset_i   = 1'b0;
        z_valid_i = '1;
        z_i       = tile1;
        ready_i   = 1'b1;
        @(posedge clk); #1;

        // Reset held with all PEs valid
        repeat (3) tick();
        chk("rst_data", data_o, 32'd0);
        chk("rst_row", 32'(row_o), 32'd0);
        chk("rst_col", 32'(col_o), 32'd0);

        // Release: capture, then stream tile1 at full rate
        reset_i = 1'b1;
        tick();
        z_valid_i = '0;
        repeat (5) tick();

        // Partial valid never captures
        z_valid_i = 4'b0111;
        repeat (10) tick();
        z_valid_i = '1;
        tick();
        z_valid_i = '0;

        // Backpressure then ready pattern 1,0,1,1,1
        ready_i = 1'b0;
        repeat (5) tick();
        beats = 0;
        ready_i = 1'b1; tick();
        ready_i = 1'b0; tick();
        ready_i = 1'b1; repeat (3) tick();
        chk("bp_beats", 32'(beats), 32'd4);
        tick();

        // Back-to-back: tile2 waits for tile1's last beat
        z_valid_i = '1;
        z_i = tile1;
        tick();
        z_i = tile2;
        repeat (4) tick();
        tick();
        z_valid_i = '0;
        z_i = '0;
        repeat (5) tick();

        // Reset after second beat discards the tile
        z_valid_i = '1;
        z_i = tile1;
        tick();
        z_valid_i = '0;
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        z_valid_i = '1;
        z_i = tile2;
        tick();
        z_valid_i = '0;
        repeat (5) tick();

        // Random grids, valid masks and ready
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < N; k++) z_i[DW*k +: DW] = $urandom;
            z_valid_i = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom_range(0, 15));
            ready_i   = ($urandom_range(0, 3) != 0);
            reset_i   = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset_i = 1'b1;
        z_valid_i = '0;
        ready_i = 1'b1;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
